// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory arbiter and its helpers.
//   arb_state_t : arbiter sequencer states
//   mem_req_t   : latched single transaction (address, direction, write data)
//   FIFO_ADDR   : address the memory map decodes as the write-only output FIFO
`include "common.svh"

package mem_pkg;

  localparam int DATA_W = `DATA_WIDTH;

  localparam logic [31:0] FIFO_ADDR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/common.svh
// Shared compile-time definitions for the memory subsystem.
`ifndef COMMON_SVH
`define COMMON_SVH
`define DATA_WIDTH 32
`endif

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin select.
//   req_i      [1:0] in   request vector (bit 0 = m0, bit 1 = m1)
//   last_gnt_i       in   requester granted last (0 = m0, 1 = m1)
//   gnt_o      [1:0] out  one-hot grant, all zero when nothing requests
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      // Contention: favour whoever did not win last time.
      gnt_o = last_gnt_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer in front of the memory map
// (BRAM with 1-cycle synchronous read + write-only output FIFO).
//   clk, rst                      clock, synchronous active-high reset
//   m0_* / m1_*                   req/addr/write/wdata in, ack/rdata/err out
//                                 (m0 = loader/debug, m1 = CPU data port)
//   mm_addr, mm_write, mm_wdata   drive the memory map CPU-side interface
//   mm_rdata, mm_invalid          read data and address-decode error from map
//   fifo_full                     output FIFO full flag
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] FIFO_ADDR = mem_pkg::FIFO_ADDR,
  parameter int          STALL_MAX = 255,
  parameter int          STALL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [31:0]       mm_addr,
  output logic              mm_write,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_invalid,
  input  logic              fifo_full
);

  localparam logic [STALL_W-1:0] CNT_LAST = STALL_W'(STALL_MAX - 1);

  arb_state_t          state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                owner_q, owner_d;
  mem_req_t            req_q, req_d;
  logic [STALL_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [1:0]          gnt;
  logic [31:0]         mm_addr_c;
  logic                mm_write_c;
  logic [DATA_W-1:0]   mm_wdata_c;
  logic                resp_c;

  rr_pick2 u_pick (
    .req_i      ({m1_req, m0_req}),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mm_addr_c  = '0;
    mm_write_c = 1'b0;
    mm_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          if (gnt[1]) begin
            req_d.addr  = m1_addr;
            req_d.write = m1_write;
            req_d.wdata = m1_wdata;
          end else begin
            req_d.addr  = m0_addr;
            req_d.write = m0_write;
            req_d.wdata = m0_wdata;
          end
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        mm_addr_c  = req_q.addr;
        mm_wdata_c = req_q.wdata;
        if (mm_invalid) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (req_q.addr == FIFO_ADDR && !req_q.write) begin
          // The FIFO has no read side.
          err_d   = 1'b1;
          state_d = RESP;
        end else if (req_q.write) begin
          if (req_q.addr == FIFO_ADDR && fifo_full) begin
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            mm_write_c = 1'b1;
            state_d    = RESP;
          end
        end else begin
          state_d = READ;
        end
      end

      READ: begin
        // BRAM output is valid one cycle after the address was presented.
        mm_addr_c = req_q.addr;
        rdata_d   = mm_rdata;
        state_d   = RESP;
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!fifo_full) begin
          // Go back through ADDR so the write is issued exactly once.
          state_d = ADDR;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        last_gnt_d = owner_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      req_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Outputs are masked while rst is high so an abandoned transaction cannot
  // write or acknowledge during the reset cycle itself.
  assign resp_c   = (state_q == RESP) && !rst;

  assign m0_ack   = resp_c && !owner_q;
  assign m1_ack   = resp_c &&  owner_q;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;

  assign mm_addr  = rst ? '0 : mm_addr_c;
  assign mm_write = mm_write_c && !rst;
  assign mm_wdata = rst ? '0 : mm_wdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a small
// memory-map model (16-word BRAM at 0x00..0x3F, output FIFO at FIFO_ADDR,
// everything else invalid). The DUT runs with STALL_MAX=8.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int          DW   = DATA_W;
  localparam logic [31:0] FIFO = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0]   m0_addr = '0, m1_addr = '0;
  logic          m0_write = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [31:0]   mm_addr;
  logic          mm_write;
  logic [DW-1:0] mm_wdata, mm_rdata;
  logic          mm_invalid;
  logic          fifo_full = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [16];
  int            wr_cnt = 0, wr_full_cnt = 0, ack0_cnt = 0, fifo_cnt = 0;
  logic [31:0]   last_wr_addr = '0;
  logic [DW-1:0] fifo_last = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIFO_ADDR(FIFO), .STALL_MAX(8), .STALL_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mm_addr(mm_addr), .mm_write(mm_write), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_invalid(mm_invalid), .fifo_full(fifo_full)
  );

  // Memory map model: BRAM contents 0x1000_0000 + word index after reset.
  assign mm_rdata   = (mm_addr < 32'h40) ? mem[mm_addr[5:2]] : '0;
  assign mm_invalid = (mm_addr >= 32'h40) && (mm_addr != FIFO);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(32'h1000_0000 + i);
    end else if (mm_write) begin
      if (mm_addr == FIFO) begin
        fifo_cnt  <= fifo_cnt + 1;
        fifo_last <= mm_wdata;
      end else if (mm_addr < 32'h40) begin
        mem[mm_addr[5:2]] <= mm_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (mm_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mm_addr;
      if (fifo_full) wr_full_cnt <= wr_full_cnt + 1;
    end
    if (m0_ack) ack0_cnt <= ack0_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one transaction from master m; caller and callee sit just after a
  // posedge. Cycle 0 is the first cycle req is high. fifo_full is high for
  // cycles 0..full_n-1. cyc = -1 if no ack within the budget.
  task automatic do_txn(input int m, input logic [31:0] a, input logic wr,
                        input logic [DW-1:0] wd, input int full_n,
                        output int cyc, output logic [DW-1:0] rd, output logic er);
    cyc = -1;
    rd  = '0;
    er  = 1'b0;
    if (m == 0) begin
      m0_req = 1'b1; m0_addr = a; m0_write = wr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_addr = a; m1_write = wr; m1_wdata = wd;
    end
    for (int c = 0; c < 40; c++) begin
      fifo_full = (c < full_n);
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        cyc = c;
        rd  = (m == 0) ? m0_rdata : m1_rdata;
        er  = (m == 0) ? m0_err : m1_err;
        check_val("other_ack_low", (m == 0) ? m1_ack : m0_ack, 0);
        break;
      end
      @(posedge clk); #1;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    fifo_full = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc, w0, wf0, f0, a0, n;
    logic [DW-1:0] rd;
    logic          er;
    int            seq_m [4];
    logic [DW-1:0] seq_d [4];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_mm_write", mm_write, 0);
    check_val("rst_m0_ack", m0_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check_val("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check_val("rst_mm", {mm_addr, mm_write, mm_wdata}, 0);
    @(posedge clk); #1;

    // 1: m1 write 0x10 <- 0xA5, then read it back
    w0 = wr_cnt;
    do_txn(1, 32'h10, 1'b1, DW'(32'hA5), 0, cyc, rd, er);
    check_val("t1_wr_cycle", cyc, 2);
    check_val("t1_wr_err", er, 0);
    check_val("t1_wr_rdata", rd, 0);
    check_val("t1_wr_count", wr_cnt - w0, 1);
    check_val("t1_wr_addr", last_wr_addr, 32'h10);
    do_txn(1, 32'h10, 1'b0, '0, 0, cyc, rd, er);
    check_val("t1_rd_cycle", cyc, 3);
    check_val("t1_rd_data", rd, 32'hA5);
    check_val("t1_rd_err", er, 0);

    // 2: both hold req with reads of 0x4 (m0) and 0x8 (m1)
    m0_req = 1'b1; m0_addr = 32'h4; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h8; m1_write = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        check_val("t2_single_ack", m0_ack & m1_ack, 0);
        seq_m[n] = m1_ack ? 1 : 0;
        seq_d[n] = m1_ack ? m1_rdata : m0_rdata;
        n++;
        if (n == 4) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    check_val("t2_ack_count", n, 4);
    check_val("t2_order0", seq_m[0], 0);
    check_val("t2_order1", seq_m[1], 1);
    check_val("t2_order2", seq_m[2], 0);
    check_val("t2_order3", seq_m[3], 1);
    check_val("t2_data0", seq_d[0], 32'h1000_0001);
    check_val("t2_data1", seq_d[1], 32'h1000_0002);
    check_val("t2_data2", seq_d[2], 32'h1000_0001);
    check_val("t2_data3", seq_d[3], 32'h1000_0002);

    // 3: m0 FIFO write with fifo_full high for cycles 0..4
    w0 = wr_cnt; wf0 = wr_full_cnt; f0 = fifo_cnt;
    do_txn(0, FIFO, 1'b1, DW'(32'h41), 5, cyc, rd, er);
    check_val("t3_cycle", cyc, 7);
    check_val("t3_err", er, 0);
    check_val("t3_wr_count", wr_cnt - w0, 1);
    check_val("t3_wr_while_full", wr_full_cnt - wf0, 0);
    check_val("t3_fifo_count", fifo_cnt - f0, 1);
    check_val("t3_fifo_data", fifo_last, 32'h41);

    // 4: m1 FIFO write, FIFO never drains: 8 WAIT cycles then error
    w0 = wr_cnt; f0 = fifo_cnt;
    do_txn(1, FIFO, 1'b1, DW'(32'h77), 100, cyc, rd, er);
    check_val("t4_cycle", cyc, 10);
    check_val("t4_err", er, 1);
    check_val("t4_rdata", rd, 0);
    check_val("t4_no_write", wr_cnt - w0, 0);
    check_val("t4_no_fifo", fifo_cnt - f0, 0);

    // 5: unmapped read, then FIFO read
    w0 = wr_cnt;
    do_txn(1, 32'h8000_0000, 1'b0, '0, 0, cyc, rd, er);
    check_val("t5_inv_cycle", cyc, 2);
    check_val("t5_inv_err", er, 1);
    check_val("t5_inv_rdata", rd, 0);
    do_txn(1, FIFO, 1'b0, '0, 0, cyc, rd, er);
    check_val("t5_fifo_cycle", cyc, 2);
    check_val("t5_fifo_err", er, 1);
    check_val("t5_fifo_rdata", rd, 0);
    check_val("t5_no_write", wr_cnt - w0, 0);

    // 6: reset during m0 READ (cycle 2), then an m1 read
    a0 = ack0_cnt;
    m0_req = 1'b1; m0_addr = 32'h4; m0_write = 1'b0;
    @(negedge clk); @(posedge clk); #1;   // cycle 0 (IDLE)
    @(negedge clk); @(posedge clk); #1;   // cycle 1 (ADDR)
    rst = 1'b1;                           // cycle 2 (READ)
    m0_req = 1'b0;
    @(negedge clk);
    check_val("t6_rst_cycle_write", mm_write, 0);
    check_val("t6_rst_cycle_ack", m0_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check_val("t6_rdata", {m0_rdata, m1_rdata}, 0);
    check_val("t6_mm", {mm_addr, mm_write, mm_wdata}, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val("t6_no_m0_ack", ack0_cnt - a0, 0);
    do_txn(1, 32'h8, 1'b0, '0, 0, cyc, rd, er);
    check_val("t6_rd_cycle", cyc, 3);
    check_val("t6_rd_data", rd, 32'h1000_0002);
    check_val("t6_rd_err", er, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
